// File: rtl/timer_pkg.sv
// Shared register map, CTRL field positions and the timer value type for the machine timer.
package timer_pkg;

    localparam logic [4:0] MTIME_LO_OFS    = 5'h00;
    localparam logic [4:0] MTIME_HI_OFS    = 5'h04;
    localparam logic [4:0] MTIMECMP_LO_OFS = 5'h08;
    localparam logic [4:0] MTIMECMP_HI_OFS = 5'h0C;
    localparam logic [4:0] CTRL_OFS        = 5'h10;

    localparam int unsigned CTRL_EN_BIT       = 0;
    localparam int unsigned CTRL_PRESCALE_LSB = 16;

    typedef logic [63:0] timer_val_t;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler down counter: emits a one-cycle tick every PRESCALE+1 enabled cycles.
module timer_prescaler #(
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_load,
    input  logic [PRESCALE_W-1:0] i_load_val,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_tick
);

    logic [PRESCALE_W-1:0] r_count;

    // A reload from the bus suppresses the tick for that cycle.
    assign o_tick = i_en && !i_load && (r_count == '0);

    // Count down while enabled, reload on expiry or on a CTRL write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            if (r_count == '0) begin
                r_count <= i_prescale;
            end else begin
                r_count <= r_count - PRESCALE_W'(1);
            end
        end
    end

endmodule

// File: rtl/machine_timer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp, prescaled tick, MTIP and a 32-bit register port.
module machine_timer
    import timer_pkg::*;
#(
    parameter int unsigned PRESCALE_W  = 16,
    parameter logic        CTRL_RST_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [4:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        timer_irq,
    output logic        tick_o
);

    timer_val_t            r_mtime;
    timer_val_t            r_mtimecmp;
    logic                  r_en;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [31:0]           r_snapshot;
    logic                  r_rsp_valid;
    logic [31:0]           r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_irq;
    logic                  r_tick;

    logic                  w_err;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_ctrl_wr;
    logic                  w_tick;
    logic [31:0]           w_rdata;

    assign req_ready = 1'b1;
    assign w_err     = (req_addr[1:0] != 2'b00) || (req_addr > CTRL_OFS);
    assign w_wr      = req_valid && req_we && !w_err;
    assign w_rd      = req_valid && !req_we && !w_err;
    assign w_ctrl_wr = w_wr && (req_addr == CTRL_OFS);

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign timer_irq = r_irq;
    assign tick_o    = r_tick;

    timer_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .i_en      (r_en),
        .i_load    (w_ctrl_wr),
        .i_load_val(req_wdata[CTRL_PRESCALE_LSB +: PRESCALE_W]),
        .i_prescale(r_prescale),
        .o_tick    (w_tick)
    );

    // Read mux over the pre-update register values.
    always_comb begin
        w_rdata = '0;
        case (req_addr)
            MTIME_LO_OFS:    w_rdata = r_mtime[31:0];
            MTIME_HI_OFS:    w_rdata = r_snapshot;
            MTIMECMP_LO_OFS: w_rdata = r_mtimecmp[31:0];
            MTIMECMP_HI_OFS: w_rdata = r_mtimecmp[63:32];
            CTRL_OFS: begin
                w_rdata[CTRL_PRESCALE_LSB +: PRESCALE_W] = r_prescale;
                w_rdata[CTRL_EN_BIT]                     = r_en;
            end
            default:         w_rdata = '0;
        endcase
    end

    // mtime: a bus write to either half wins over a same-cycle tick, dropping that increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtime <= '0;
        end else if (w_wr && (req_addr == MTIME_LO_OFS)) begin
            r_mtime[31:0] <= req_wdata;
        end else if (w_wr && (req_addr == MTIME_HI_OFS)) begin
            r_mtime[63:32] <= req_wdata;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    // mtimecmp halves, written independently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtimecmp <= '1;
        end else if (w_wr && (req_addr == MTIMECMP_LO_OFS)) begin
            r_mtimecmp[31:0] <= req_wdata;
        end else if (w_wr && (req_addr == MTIMECMP_HI_OFS)) begin
            r_mtimecmp[63:32] <= req_wdata;
        end
    end

    // CTRL register: enable and prescale reload value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en       <= CTRL_RST_EN;
            r_prescale <= '0;
        end else if (w_ctrl_wr) begin
            r_en       <= req_wdata[CTRL_EN_BIT];
            r_prescale <= req_wdata[CTRL_PRESCALE_LSB +: PRESCALE_W];
        end
    end

    // Capture the upper half on a low-half read so LO-then-HI reads are atomic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snapshot <= '0;
        end else if (w_rd && (req_addr == MTIME_LO_OFS)) begin
            r_snapshot <= r_mtime[63:32];
        end
    end

    // Registered response, one cycle after each accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= req_valid;
            r_rsp_rdata <= w_rd ? w_rdata : '0;
            r_rsp_err   <= req_valid && w_err;
        end
    end

    // Registered MTIP compare and tick output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_irq  <= (r_mtime >= r_mtimecmp);
            r_tick <= w_tick;
        end
    end

endmodule

// File: tb/tb_machine_timer.sv
// Randomized and directed bench for machine_timer against a behavioural register-level model.
module tb_machine_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        timer_irq;
    logic        tick_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [63:0] m_time;
    logic [63:0] m_cmp;
    logic        m_en;
    logic [15:0] m_presc;
    int unsigned m_phase;
    logic [31:0] m_snap;

    // Expected outputs after the coming edge
    logic        e_valid;
    logic        e_err;
    logic        e_irq;
    logic        e_tick;
    logic        e_chk;
    logic [31:0] e_rdata;

    logic [31:0] last_rdata;
    logic        last_err;

    // Random stimulus scratch
    logic        s_v;
    logic        s_we;
    logic        s_rst;
    logic [4:0]  s_addr;
    logic [31:0] s_data;
    logic [15:0] s_p;
    int unsigned s_sel;

    always #5 clk = ~clk;

    machine_timer #(
        .PRESCALE_W (16),
        .CTRL_RST_EN(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .timer_irq(timer_irq),
        .tick_o   (tick_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Phase counts enabled cycles since the last reload; a tick happens when it reaches PRESCALE.
    task automatic model_step(input logic v, input logic we, input logic [4:0] a,
                              input logic [31:0] d, input logic r);
        logic        err;
        logic        ctrl_wr;
        logic        tick;
        logic [63:0] t;
        if (r) begin
            m_time  = 64'd0;
            m_cmp   = {64{1'b1}};
            m_en    = 1'b1;
            m_presc = 16'd0;
            m_phase = 0;
            m_snap  = 32'd0;
            e_valid = 1'b0;
            e_err   = 1'b0;
            e_irq   = 1'b0;
            e_tick  = 1'b0;
            e_rdata = 32'd0;
            e_chk   = 1'b1;
        end else begin
            err     = (a % 4 != 0) || (a > 5'd16);
            ctrl_wr = v && we && !err && (a == 5'd16);
            tick    = m_en && (m_phase == m_presc) && !ctrl_wr;
            e_valid = v;
            e_chk   = v;
            e_err   = v && err;
            e_irq   = (m_time >= m_cmp);
            e_tick  = tick;
            e_rdata = 32'd0;
            if (v && !we && !err) begin
                case (a)
                    5'd0:    e_rdata = m_time[31:0];
                    5'd4:    e_rdata = m_snap;
                    5'd8:    e_rdata = m_cmp[31:0];
                    5'd12:   e_rdata = m_cmp[63:32];
                    default: e_rdata = {m_presc, 15'd0, m_en};
                endcase
                if (a == 5'd0) m_snap = m_time[63:32];
            end
            t = tick ? m_time + 64'd1 : m_time;
            if (v && we && !err) begin
                case (a)
                    5'd0:    t = {m_time[63:32], d};
                    5'd4:    t = {d, m_time[31:0]};
                    5'd8:    m_cmp[31:0] = d;
                    5'd12:   m_cmp[63:32] = d;
                    default: ;
                endcase
            end
            if (ctrl_wr) begin
                m_phase = 0;
                m_en    = d[0];
                m_presc = d[31:16];
            end else if (m_en) begin
                m_phase = (m_phase == m_presc) ? 0 : m_phase + 1;
            end
            m_time = t;
        end
    endtask

    task automatic cycle(input logic v, input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic r);
        rst       = r;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        model_step(v, we, a, d, r);
        @(posedge clk);
        #1;
        check("req_ready", req_ready, 1'b1);
        check("rsp_valid", rsp_valid, e_valid);
        if (e_chk) begin
            check("rsp_rdata", rsp_rdata, e_rdata);
            check("rsp_err", rsp_err, e_err);
        end
        check("timer_irq", timer_irq, e_irq);
        check("tick_o", tick_o, e_tick);
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
    endtask

    task automatic bus(input logic we, input logic [4:0] a, input logic [31:0] d);
        cycle(1'b1, we, a, d, 1'b0);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    initial begin
        // Reset values
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        check("rst_irq", timer_irq, 1'b0);
        bus(1'b0, 5'h10, 32'd0);
        check("rst_ctrl", last_rdata, 32'h0000_0001);
        bus(1'b0, 5'h08, 32'd0);
        check("rst_cmp_lo", last_rdata, 32'hFFFF_FFFF);
        bus(1'b0, 5'h0C, 32'd0);
        check("rst_cmp_hi", last_rdata, 32'hFFFF_FFFF);

        // Prescale of 3: one increment per 4 cycles
        bus(1'b1, 5'h04, 32'd0);
        bus(1'b1, 5'h00, 32'd0);
        bus(1'b1, 5'h10, 32'h0003_0001);
        idle(16);
        bus(1'b0, 5'h00, 32'd0);
        check("presc3_mtime", last_rdata, 32'd4);

        // Carry from low to high half, then full 64-bit wrap
        bus(1'b1, 5'h10, 32'h0000_0001);
        bus(1'b1, 5'h04, 32'd0);
        bus(1'b1, 5'h00, 32'hFFFF_FFFF);
        idle(1);
        bus(1'b0, 5'h00, 32'd0);
        check("carry_lo", last_rdata, 32'd0);
        bus(1'b0, 5'h04, 32'd0);
        check("carry_hi", last_rdata, 32'd1);
        bus(1'b1, 5'h04, 32'hFFFF_FFFF);
        bus(1'b1, 5'h00, 32'hFFFF_FFFF);
        idle(1);
        bus(1'b0, 5'h00, 32'd0);
        check("wrap_lo", last_rdata, 32'd0);
        bus(1'b0, 5'h04, 32'd0);
        check("wrap_hi", last_rdata, 32'd0);

        // Compare: irq rises one cycle after mtime reaches 10, clears 2 cycles after cmp write
        bus(1'b1, 5'h04, 32'd0);
        bus(1'b1, 5'h00, 32'd0);
        bus(1'b1, 5'h0C, 32'd0);
        bus(1'b1, 5'h08, 32'd10);
        idle(8);
        check("irq_before", timer_irq, 1'b0);
        idle(1);
        check("irq_rise", timer_irq, 1'b1);
        bus(1'b1, 5'h08, 32'hFFFF_FFFF);
        check("irq_hold", timer_irq, 1'b1);
        idle(1);
        check("irq_clear", timer_irq, 1'b0);

        // Snapshot keeps the high half seen at the low-half read
        bus(1'b1, 5'h04, 32'd5);
        bus(1'b1, 5'h00, 32'hFFFF_FFF0);
        bus(1'b0, 5'h00, 32'd0);
        check("snap_lo", last_rdata, 32'hFFFF_FFF0);
        idle(20);
        bus(1'b0, 5'h04, 32'd0);
        check("snap_hi_old", last_rdata, 32'd5);
        bus(1'b0, 5'h00, 32'd0);
        bus(1'b0, 5'h04, 32'd0);
        check("snap_hi_new", last_rdata, 32'd6);

        // Write in a tick cycle wins over the increment
        bus(1'b1, 5'h00, 32'h0000_0100);
        bus(1'b0, 5'h00, 32'd0);
        check("collide_lo", last_rdata, 32'h0000_0100);

        // Error offsets
        foreach (s_addr[i]) begin end
        for (int unsigned k = 0; k < 3; k++) begin
            s_addr = (k == 0) ? 5'h02 : (k == 1) ? 5'h14 : 5'h1C;
            bus(1'b1, s_addr, 32'hDEAD_BEEF);
            check("err_wr_flag", last_err, 1'b1);
            check("err_wr_data", last_rdata, 32'd0);
            bus(1'b0, s_addr, 32'd0);
            check("err_rd_flag", last_err, 1'b1);
            check("err_rd_data", last_rdata, 32'd0);
        end
        bus(1'b0, 5'h10, 32'd0);
        check("err_ctrl_kept", last_rdata, 32'h0000_0001);
        bus(1'b0, 5'h08, 32'd0);
        check("err_cmp_kept", last_rdata, 32'hFFFF_FFFF);

        // Reset with a read in flight drops the response
        cycle(1'b1, 1'b0, 5'h10, 32'd0, 1'b1);
        check("rst_drop", rsp_valid, 1'b0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);

        // Randomized traffic
        for (int unsigned n = 0; n < 3000; n++) begin
            s_v   = ($urandom_range(0, 3) != 0);
            s_we  = $urandom_range(0, 1);
            s_rst = ($urandom_range(0, 299) == 0);
            s_sel = $urandom_range(0, 19);
            s_data = $urandom;
            if (s_sel < 4) begin
                s_addr = 5'h00;
                if ($urandom_range(0, 1) == 1) s_data = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            end else if (s_sel < 8) begin
                s_addr = 5'h04;
                if ($urandom_range(0, 1) == 1) s_data = m_time[63:32];
            end else if (s_sel < 11) begin
                s_addr = 5'h08;
                s_data = m_time[31:0] + $urandom_range(0, 40);
            end else if (s_sel < 13) begin
                s_addr = 5'h0C;
                s_data = m_time[63:32] + $urandom_range(0, 1);
            end else if (s_sel < 17) begin
                s_addr = 5'h10;
                s_p    = 16'($urandom_range(0, 3));
                s_data[31:16] = s_p;
                s_data[0]     = ($urandom_range(0, 9) != 0);
            end else begin
                s_addr = 5'($urandom);
            end
            cycle(s_v, s_we, s_addr, s_data, s_rst);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
